shift_add_multiplier: RTL and testbench



---
 rtl/shift_add_multiplier.sv | 103 ++++++++++
 tb/tb_shift_add_multiplier.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned WIDTH x WIDTH multiplier, MSB-first shift-and-add, one
// multiplier bit per clock. start/busy/done handshake; P holds the last product.
module shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] P
);

  // state  | meaning
  // S_IDLE | waiting for start; P holds last product
  // S_RUN  | one multiplier bit consumed per clock, idx counts down to 0
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] acc_shift;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;

  // Full-width shift and add: the running sum never exceeds 2*WIDTH bits.
  always_comb begin
    acc_shift = acc_q << 1;
    addend    = b_q[idx_q] ? {{WIDTH{1'b0}}, a_q} : '0;
    acc_next  = acc_shift + addend;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    p_d     = p_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          acc_d   = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (idx_q != '0) begin
          acc_d = acc_next;
          idx_d = idx_q - IW'(1);
        end else begin
          p_d     = acc_next;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      p_q     <= p_d;
      done_q  <= done_d;
    end
  end

  // busy follows the state register, so it drops on the same edge done rises.
  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and randomized checks of shift_add_multiplier at WIDTH = 8, 4 and 16.
module tb_shift_add_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        start8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        start4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  logic        start16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  shift_add_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8));

  shift_add_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4),
    .busy(busy4), .done(done4), .P(p4));

  shift_add_multiplier #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .P(p16));

  always @(negedge clk)
    if ((busy8 && done8) || (busy4 && done4) || (busy16 && done16)) overlap++;

  // One WIDTH=8 operation; lat = negedges after the accepting edge until done.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start8 = 0; a8 = '0; b8 = '0;
    start4 = 0; a4 = '0; b4 = '0;
    start16 = 0; a16 = '0; b16 = '0;
    #12;
    n_checks++;
    if ({busy8, done8, p8} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset8: busy=%b done=%b P=%h, required 0 0 0000", busy8, done8, p8);
    end
    n_checks++;
    if ({busy4, done4, p4, busy16, done16, p16} !== 44'd0) begin
      n_fail++;
      $display("FAIL reset4_16: P4=%h P16=%h busy=%b%b done=%b%b, required all 0",
               p4, p16, busy4, busy16, done4, done16);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int cycles;
    @(negedge clk);
    a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cycles = 0;
    while (busy8 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    n_checks++;
    if (cycles !== 8) begin
      n_fail++;
      $display("FAIL basic_busy_len: busy cycles=%0d, required 8", cycles);
    end
    n_checks++;
    if (done8 !== 1'b1 || busy8 !== 1'b0 || p8 !== 16'h008F) begin
      n_fail++;
      $display("FAIL basic_done: done=%b busy=%b P=%h, required 1 0 008f", done8, busy8, p8);
    end
    @(negedge clk);
    n_checks++;
    if (done8 !== 1'b0 || p8 !== 16'h008F) begin
      n_fail++;
      $display("FAIL basic_done_drop: done=%b P=%h, required 0 008f", done8, p8);
    end
  endtask

  task automatic test_corners;
    int lat;
    op8(8'd255, 8'd255, lat);
    n_checks++;
    if (lat !== 8 || p8 !== 16'hFE01) begin
      n_fail++;
      $display("FAIL corner_255x255: lat=%0d P=%h, required 8 fe01", lat, p8);
    end
    op8(8'd0, 8'd200, lat);
    n_checks++;
    if (lat !== 8 || p8 !== 16'h0000) begin
      n_fail++;
      $display("FAIL corner_0x200: lat=%0d P=%h, required 8 0000", lat, p8);
    end
    op8(8'd1, 8'd128, lat);
    n_checks++;
    if (lat !== 8 || p8 !== 16'h0080) begin
      n_fail++;
      $display("FAIL corner_1x128: lat=%0d P=%h, required 8 0080", lat, p8);
    end
    op8(8'd128, 8'd1, lat);
    n_checks++;
    if (lat !== 8 || p8 !== 16'h0080) begin
      n_fail++;
      $display("FAIL corner_128x1: lat=%0d P=%h, required 8 0080", lat, p8);
    end
  endtask

  task automatic test_ignore_start;
    int dones;
    logic [15:0] p_at_done;
    @(negedge clk);
    a8 = 8'd13; b8 = 8'd11; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    dones = 0;
    p_at_done = '0;
    for (int k = 0; k < 20; k++) begin
      if (busy8) begin
        a8 = (k % 2 == 0) ? 8'd2 : 8'd200;
        b8 = (k % 2 == 0) ? 8'd2 : 8'd77;
        start8 = (k >= 1 && k <= 4);
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      if (done8) begin
        dones++;
        p_at_done = p8;
      end
    end
    start8 = 1'b0;
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: done pulses=%0d, required 1", dones);
    end
    n_checks++;
    if (p_at_done !== 16'd143 || p8 !== 16'd143) begin
      n_fail++;
      $display("FAIL ignore_product: P=%0d (at done %0d), required 143", p8, p_at_done);
    end
  endtask

  task automatic test_async_reset;
    int lat;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd3; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b1 || p8 !== 16'd143) begin
      n_fail++;
      $display("FAIL areset_pre: busy=%b P=%0d, required 1 143", busy8, p8);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || p8 !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_immediate: busy=%b done=%b P=%h, required 0 0 0000", busy8, done8, p8);
    end
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (done8 !== 1'b0 || p8 !== 16'd0) begin
      n_fail++;
      $display("FAIL areset_hold: done=%b P=%h, required 0 0000", done8, p8);
    end
    op8(8'd7, 8'd6, lat);
    n_checks++;
    if (lat !== 8 || p8 !== 16'd42) begin
      n_fail++;
      $display("FAIL areset_recover: lat=%0d P=%0d, required 8 42", lat, p8);
    end
  endtask

  task automatic test_back_to_back;
    int wait_n, gap;
    bit held_ok;
    @(negedge clk);
    a8 = 8'd5; b8 = 8'd9; start8 = 1'b1;
    wait_n = 0;
    while (!done8 && wait_n < 40) begin
      @(negedge clk);
      wait_n++;
    end
    n_checks++;
    if (wait_n !== 9 || p8 !== 16'd45) begin
      n_fail++;
      $display("FAIL b2b_first: cycles=%0d P=%0d, required 9 45", wait_n, p8);
    end
    a8 = 8'd10; b8 = 8'd10;
    gap = 0;
    held_ok = 1'b1;
    do begin
      @(negedge clk);
      gap++;
      if (!done8 && p8 !== 16'd45) held_ok = 1'b0;
    end while (!done8 && gap < 40);
    start8 = 1'b0;
    n_checks++;
    if (gap !== 9 || p8 !== 16'd100) begin
      n_fail++;
      $display("FAIL b2b_second: gap=%0d P=%0d, required 9 100", gap, p8);
    end
    n_checks++;
    if (held_ok !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_hold: P left 45 before completion, required stable 45");
    end
    @(negedge clk);
    n_checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: busy=%b done=%b, required 0 0", busy8, done8);
    end
  endtask

  task automatic test_width4;
    int lat;
    @(negedge clk);
    a4 = 4'd15; b4 = 4'd15; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 4 || p4 !== 8'hE1) begin
      n_fail++;
      $display("FAIL w4_15x15: lat=%0d P=%h, required 4 e1", lat, p4);
    end
    @(negedge clk);
    a4 = 4'd9; b4 = 4'd6; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat !== 4 || p4 !== 8'd54) begin
      n_fail++;
      $display("FAIL w4_9x6: lat=%0d P=%0d, required 4 54", lat, p4);
    end
  endtask

  task automatic test_random8;
    int lat, bad;
    logic [7:0]  a, b;
    logic [15:0] expv;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      expv = 16'(a) * 16'(b);
      op8(a, b, lat);
      n_checks++;
      if (lat !== 8 || p8 !== expv) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand8 %0d*%0d: lat=%0d P=%0d, required 8 %0d", a, b, lat, p8, expv);
        bad++;
      end
    end
  endtask

  task automatic test_random16;
    int lat, bad;
    logic [15:0] a, b;
    logic [31:0] expv;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(0, 65535));
      if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
      expv = 32'(a) * 32'(b);
      @(negedge clk);
      a16 = a; b16 = b; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 0;
      while (!done16 && lat < 60) begin
        @(negedge clk);
        lat++;
      end
      n_checks++;
      if (lat !== 16 || p16 !== expv) begin
        n_fail++;
        if (bad < 10)
          $display("FAIL rand16 %0d*%0d: lat=%0d P=%0d, required 16 %0d", a, b, lat, p16, expv);
        bad++;
      end
    end
  endtask

  task automatic test_no_overlap;
    n_checks++;
    if (overlap !== 0) begin
      n_fail++;
      $display("FAIL busy_done_overlap: cycles with both high=%0d, required 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_ignore_start();
    test_async_reset();
    test_back_to_back();
    test_width4();
    test_random8();
    test_random16();
    test_no_overlap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
